// File: rtl/snn_stdp_pkg.sv
// Shared types and constants for the STDP weight-update scheduler.
//   state_e      : scheduler FSM states
//   DT_W, W_W    : default delta-t and weight widths
//   W_MAX, W_MIN : saturation limits for the default weight width
package snn_stdp_pkg;

  localparam int unsigned DT_W = 8;
  localparam int unsigned W_W  = 24;

  localparam logic signed [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
  localparam logic signed [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StAdd,
    StOut
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; search runs upward from here and wraps
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the granted bit (0 when no request)
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IdW = $clog2(N_REQ);

  logic           found;
  logic [IdW-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = IdW'((32'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/stdp_update_sched.sv
// Shares one registered LTD lookup table among N_REQ synapse-update requesters.
// Each granted request is looked up, added to its weight with signed saturation
// and presented on a valid/ready result channel. One request in flight at a time.
//   clk, rst       : clock, synchronous active-high reset
//   req_valid/dt/w : per-requester request, packed delta-t and current weight
//   req_ready      : one-hot accept strobe (IDLE only)
//   lut_in/lut_out : registered LUT address, LUT data one cycle later
//   upd_valid/id/w : saturated result, requester index; upd_ready consumes it
module stdp_update_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DT_W  = snn_stdp_pkg::DT_W,
  parameter int unsigned W_W   = snn_stdp_pkg::W_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DT_W-1:0]    req_dt,
  input  logic [N_REQ*W_W-1:0]     req_w,
  output logic [N_REQ-1:0]         req_ready,
  output logic [DT_W-1:0]          lut_in,
  input  logic [W_W-1:0]           lut_out,
  output logic                     upd_valid,
  output logic [$clog2(N_REQ)-1:0] upd_id,
  output logic [W_W-1:0]           upd_w,
  input  logic                     upd_ready
);

  import snn_stdp_pkg::*;

  localparam int unsigned IdW = $clog2(N_REQ);
  localparam logic [W_W-1:0] SatMax = {1'b0, {(W_W-1){1'b1}}};
  localparam logic [W_W-1:0] SatMin = {1'b1, {(W_W-1){1'b0}}};

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, id_q;
  logic [W_W-1:0] w_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdW-1:0]   arb_idx;

  logic [W_W:0]   sum;
  logic [W_W-1:0] sat;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  // Sign-extend both operands one bit; the top two sum bits disagreeing means
  // overflow, and the top bit then gives the direction.
  always_comb begin
    sum = {w_q[W_W-1], w_q} + {lut_out[W_W-1], lut_out};
    sat = sum[W_W-1:0];
    if (sum[W_W] != sum[W_W-1]) begin
      sat = sum[W_W] ? SatMin : SatMax;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready = arb_gnt;
          state_d   = StLookup;
        end
      end
      StLookup: state_d = StAdd;
      StAdd:    state_d = StOut;
      StOut:    if (upd_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      w_q       <= '0;
      lut_in    <= '0;
      upd_valid <= 1'b0;
      upd_id    <= '0;
      upd_w     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (|req_valid) begin
            id_q   <= arb_idx;
            w_q    <= req_w[W_W*arb_idx +: W_W];
            lut_in <= req_dt[DT_W*arb_idx +: DT_W];
            ptr_q  <= (arb_idx == IdW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
          end
        end
        StAdd: begin
          upd_w     <= sat;
          upd_id    <= id_q;
          upd_valid <= 1'b1;
          lut_in    <= '0;
        end
        StOut: begin
          if (upd_ready) upd_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
